ex_muldiv: RTL
==============

Name: ex_muldiv

Overview:
RV32M multiply/divide unit in the execute stage. It sits directly upstream of the memory stage and drives the EX/MEM aluresult field for M-extension ops. Multiplies finish in a fixed number of cycles. Divides and remainders use an iterative 32-step restoring algorithm. The unit holds the front of the pipeline via stall_o until its result is ready for EX/MEM capture.

Parameters:
MUL_LATENCY, 2, cycles from accept to result_valid_o for MUL* ops; legal range 1..4.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
valid_i  input  1  EX stage holds an M-extension instruction (opcode OP, funct7=0000001).
funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
srca_i  input  32  rs1 operand, forwarded.
srcb_i  input  32  rs2 operand, forwarded.
flush_i  input  1  branch/jump flush of the EX stage.
stall_o  output  1  holds IF/ID/EX; EX/MEM inserts a bubble while high.
result_valid_o  output  1  result_o is valid this cycle; EX/MEM captures it.
result_o  output  32  rd value.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE, counter=0, result_o=0, result_valid_o=0.
  - reset overrides all other inputs, including mid-operation.
- States:
  - IDLE, MUL, DIV, DONE.
  - IDLE->MUL: valid_i=1 and funct3_i[2]=0.
  - IDLE->DIV: valid_i=1 and funct3_i[2]=1, normal case.
  - IDLE->DONE: special-case divide.
  - MUL->DONE: after MUL_LATENCY-1 cycles in MUL. If MUL_LATENCY=1, go IDLE->DONE directly.
  - DIV->DONE: after 32 iterations.
  - DONE->IDLE: unconditional.
- Accept (cycle 0):
  - occurs in IDLE with valid_i=1.
  - srca_i, srcb_i and funct3_i are registered. Later changes on those inputs are ignored until the next accept.
- stall_o:
  - combinational: stall_o = valid_i & (state != DONE) & ~flush_i.
  - high on the accept cycle and every busy cycle.
  - low in DONE, so the pipeline advances in the same cycle EX/MEM captures result_o.
- result_valid_o:
  - high exactly one cycle, in DONE.
  - result_o is held stable during DONE.
  - result_o is don't-care outside DONE, but the register keeps its last value.
- Latency, accept to DONE:
  - MUL*: MUL_LATENCY.
  - DIV/DIVU/REM/REMU: 33.
  - Divide special cases: 1.
- Multiply:
  - 33x33 signed product.
  - MUL, MULH: both operands sign-extended.
  - MULHSU: rs1 sign-extended, rs2 zero-extended.
  - MULHU: both zero-extended.
  - MUL returns bits [31:0]; the others return bits [63:32].
  - Pipelined across MUL_LATENCY register stages.
- Divide:
  - Signed ops take absolute values at accept.
  - Unsigned 32-iteration restoring divide: one quotient bit per cycle, MSB first, 33-bit partial remainder.
  - At DIV->DONE, the quotient is negated when operand signs differ (DIV).
  - The remainder takes the dividend's sign (REM).
- Special cases, resolved at accept, go to DONE next cycle:
  - Divisor=0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM only): DIV -> 0x80000000, REM -> 0.
- Flush:
  - flush_i=1 in any state: next state IDLE, result_valid_o=0 next cycle, in-flight result discarded.
  - If flush_i=1 in IDLE, no accept occurs even when valid_i=1.
- Back-to-back ops:
  - After DONE the unit is in IDLE.
  - A new valid_i in that cycle is accepted. Minimum spacing is one IDLE cycle between results.
- Non-M instructions: valid_i=0. The unit stays IDLE and stall_o=0.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3), MUL_LATENCY=2, accept at cycle 0 -> stall_o=1 on cycles 0-1; result_valid_o=1 at cycle 2 with result_o=0xFFFFFFEB; IDLE at cycle 3.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Each has result_valid_o at cycle 33, stall_o high on cycles 0-32.
- DIVU 0x1234/0 -> 0xFFFFFFFF and REMU 0x1234/0 -> 0x1234, both valid at cycle 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM of the same -> 0, valid at cycle 1.
- DIV accepted at cycle 0, flush_i=1 at cycle 10 -> IDLE at cycle 11, no result_valid_o pulse. MUL 3x5 accepted at cycle 11 -> result_o=15 at cycle 13.
- reset=1 at cycle 5 of a DIV -> cycle 6: IDLE, result_o=0, result_valid_o=0, stall_o=0 while valid_i=0. Operand changes after accept do not affect the result.

Source files
------------

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Brief    : RV32M multiply/divide unit for the execute stage. Pipelined
//            multiply, 32-step restoring divide, stalls the front end.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] srca_i,
    input  logic [31:0] srcb_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        result_valid_o,
    output logic [31:0] result_o
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_MUL   = 2'd1;
    localparam logic [1:0] c_ST_DIV   = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;
    localparam logic [4:0] c_MUL_LAST = (MUL_LATENCY >= 2) ? 5'(MUL_LATENCY - 2) : 5'd0;
    localparam logic [4:0] c_DIV_LAST = 5'd31;

    logic [1:0]  r_state, w_state_next;
    logic [4:0]  r_count;
    logic [31:0] r_result;
    logic [31:0] r_quo, r_rem, r_divisor;
    logic        r_neg_q, r_neg_r, r_rem_sel;

    logic        w_accept;
    logic        w_sign_a, w_sign_b;
    logic [63:0] w_prod;
    logic [31:0] w_mul_sel, w_mul_res;
    logic        w_div_signed, w_div_zero, w_div_ovf, w_special;
    logic [31:0] w_special_val, w_abs_a, w_abs_b;
    logic [32:0] w_rem_shift, w_rem_diff;
    logic        w_q_bit;
    logic [31:0] w_rem_next, w_quo_next, w_div_res;
    logic [31:0] w_done_val;

    assign w_accept       = (r_state == c_ST_IDLE) & valid_i & ~flush_i;
    assign stall_o        = valid_i & (r_state != c_ST_DONE) & ~flush_i;
    assign result_valid_o = (r_state == c_ST_DONE);
    assign result_o       = r_result;

    // 33x33 signed product; the low 64 bits are exact after extending to 64.
    assign w_sign_a  = (funct3_i[1:0] != 2'b11) & srca_i[31];
    assign w_sign_b  = ~funct3_i[1] & srcb_i[31];
    assign w_prod    = {{32{w_sign_a}}, srca_i} * {{32{w_sign_b}}, srcb_i};
    assign w_mul_sel = (funct3_i[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];

    generate
        if (MUL_LATENCY == 1) begin : g_mul_direct
            assign w_mul_res = w_mul_sel;
        end else begin : g_mul_pipe
            logic [31:0] r_mpipe [MUL_LATENCY-1];
            always_ff @(posedge clk) begin
                if (w_accept) begin
                    r_mpipe[0] <= w_mul_sel;
                end
                for (int i = 1; i < MUL_LATENCY - 1; i++) begin
                    r_mpipe[i] <= r_mpipe[i-1];
                end
            end
            assign w_mul_res = r_mpipe[MUL_LATENCY-2];
        end
    endgenerate

    assign w_div_signed  = ~funct3_i[0];
    assign w_div_zero    = (srcb_i == 32'd0);
    assign w_div_ovf     = w_div_signed & (srca_i == 32'h8000_0000) & (srcb_i == 32'hFFFF_FFFF);
    assign w_special     = funct3_i[2] & (w_div_zero | w_div_ovf);
    assign w_special_val = w_div_zero ? (funct3_i[1] ? srca_i : 32'hFFFF_FFFF)
                                      : (funct3_i[1] ? 32'd0  : 32'h8000_0000);
    assign w_abs_a       = (w_div_signed & srca_i[31]) ? (32'd0 - srca_i) : srca_i;
    assign w_abs_b       = (w_div_signed & srcb_i[31]) ? (32'd0 - srcb_i) : srcb_i;

    // One restoring step: the sign of the 33-bit difference picks the quotient bit.
    assign w_rem_shift = {r_rem, r_quo[31]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_divisor};
    assign w_q_bit     = ~w_rem_diff[32];
    assign w_rem_next  = w_q_bit ? w_rem_diff[31:0] : w_rem_shift[31:0];
    assign w_quo_next  = {r_quo[30:0], w_q_bit};
    assign w_div_res   = r_rem_sel ? (r_neg_r ? (32'd0 - w_rem_next) : w_rem_next)
                                   : (r_neg_q ? (32'd0 - w_quo_next) : w_quo_next);

    always_comb begin
        w_state_next = r_state;
        w_done_val   = w_mul_res;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (!funct3_i[2]) begin
                        w_state_next = (MUL_LATENCY == 1) ? c_ST_DONE : c_ST_MUL;
                    end else begin
                        w_state_next = w_special ? c_ST_DONE : c_ST_DIV;
                        w_done_val   = w_special_val;
                    end
                end
            end
            c_ST_MUL: begin
                if (r_count == c_MUL_LAST) w_state_next = c_ST_DONE;
            end
            c_ST_DIV: begin
                w_done_val = w_div_res;
                if (r_count == c_DIV_LAST) w_state_next = c_ST_DONE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
        if (flush_i) w_state_next = c_ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= 5'd0;
            r_result <= 32'd0;
        end else begin
            if (w_accept) begin
                r_count   <= 5'd0;
                r_quo     <= w_abs_a;
                r_rem     <= 32'd0;
                r_divisor <= w_abs_b;
                r_neg_q   <= w_div_signed & (srca_i[31] ^ srcb_i[31]);
                r_neg_r   <= w_div_signed & srca_i[31];
                r_rem_sel <= funct3_i[1];
            end else if (r_state == c_ST_DIV) begin
                r_count <= r_count + 5'd1;
                r_quo   <= w_quo_next;
                r_rem   <= w_rem_next;
            end else if (r_state == c_ST_MUL) begin
                r_count <= r_count + 5'd1;
            end
            if (w_state_next == c_ST_DONE && r_state != c_ST_DONE) begin
                r_result <= w_done_val;
            end
        end
    end

endmodule
`default_nettype wire
